// File: rtl/reaction_timer.sv
// Reaction-timer core: random-delay WAIT, BCD elapsed-time RUN, best-score tracking
// and false-start detection for the seven-segment game board.
module reaction_timer #(
  parameter int DIGITS    = 6,
  parameter int TICK_DIV  = 50000,
  parameter int MIN_WAIT  = 1000,
  parameter int WAIT_BITS = 11
) (
  input  logic                  clk50M,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  show_best,
  output logic [4*DIGITS-1:0]   disp,
  output logic [1:0]            state,
  output logic                  go_led,
  output logic                  false_start,
  output logic                  overflow,
  output logic                  best_valid,
  output logic                  new_best
);

  localparam int DW = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = $clog2(MIN_WAIT + (1 << WAIT_BITS)) + 1;
  localparam logic [DW-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t          fsm, fsm_nxt;
  logic            start_q, stop_q, start_e, stop_e;
  logic [15:0]     lfsr;
  logic [PW-1:0]   presc;
  logic            tick, presc_clr;
  logic [LW-1:0]   delay, delay_nxt;
  logic [DW-1:0]   count, count_nxt, best, best_nxt;
  logic            fs_nxt, ov_nxt, bv_nxt, nb_nxt;

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_e = Start & ~start_q;
  assign stop_e  = Stop & ~stop_q;
  assign tick    = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    fsm_nxt   = fsm;
    delay_nxt = delay;
    count_nxt = count;
    best_nxt  = best;
    fs_nxt    = false_start;
    ov_nxt    = overflow;
    bv_nxt    = best_valid;
    nb_nxt    = 1'b0;
    presc_clr = 1'b0;
    case (fsm)
      S_IDLE, S_DONE: begin
        if (start_e) begin
          fsm_nxt   = S_WAIT;
          delay_nxt = LW'(MIN_WAIT) + LW'(lfsr[WAIT_BITS-1:0]);
          count_nxt = '0;
          fs_nxt    = 1'b0;
          ov_nxt    = 1'b0;
          presc_clr = 1'b1;
        end
      end
      S_WAIT: begin
        if (stop_e) begin
          fsm_nxt = S_DONE;
          fs_nxt  = 1'b1;
        end else if (tick) begin
          delay_nxt = delay - LW'(1);
          if (delay == LW'(1)) begin
            fsm_nxt   = S_RUN;
            count_nxt = '0;
            presc_clr = 1'b1;
          end
        end
      end
      default: begin
        if (tick) begin
          if (count == ALL9) ov_nxt = 1'b1;
          else               count_nxt = bcd_inc(count);
        end
        // The comparison uses the post-tick count so a Stop on a tick scores the increment.
        if (stop_e) begin
          fsm_nxt = S_DONE;
          if (!ov_nxt && (!best_valid || count_nxt < best)) begin
            best_nxt = count_nxt;
            bv_nxt   = 1'b1;
            nb_nxt   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (!Reset) begin
      fsm         <= S_IDLE;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      lfsr        <= 16'h0001;
      presc       <= '0;
      delay       <= '0;
      count       <= '0;
      best        <= ALL9;
      false_start <= 1'b0;
      overflow    <= 1'b0;
      best_valid  <= 1'b0;
      new_best    <= 1'b0;
    end else begin
      fsm         <= fsm_nxt;
      start_q     <= Start;
      stop_q      <= Stop;
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      presc       <= (presc_clr || tick) ? '0 : presc + PW'(1);
      delay       <= delay_nxt;
      count       <= count_nxt;
      best        <= best_nxt;
      false_start <= fs_nxt;
      overflow    <= ov_nxt;
      best_valid  <= bv_nxt;
      new_best    <= nb_nxt;
    end
  end

  assign disp   = show_best ? best : count;
  assign state  = fsm;
  assign go_led = (fsm == S_RUN);

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: stimulus queues expected state-change events,
// a negedge monitor pops and compares them as the DUT changes state.
module tb_reaction_timer;

  logic       clk50M = 1'b0;
  logic       Reset, Start, Stop, show_best;
  logic [7:0] disp;
  logic [1:0] state;
  logic       go_led, false_start, overflow, best_valid, new_best;

  reaction_timer #(.DIGITS(2), .TICK_DIV(4), .MIN_WAIT(3), .WAIT_BITS(2)) dut (
    .clk50M(clk50M), .Reset(Reset), .Start(Start), .Stop(Stop), .show_best(show_best),
    .disp(disp), .state(state), .go_led(go_led), .false_start(false_start),
    .overflow(overflow), .best_valid(best_valid), .new_best(new_best)
  );

  initial forever #5 clk50M = ~clk50M;

  typedef struct {
    string      name;
    int         cyc;
    logic [14:0] vec;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] ref_lfsr = 16'h0001;
  logic        mon_en = 1'b0;
  logic        chk_nb = 1'b0;
  logic [1:0]  prev_state = 2'b00;

  always @(posedge clk50M) cyc <= cyc + 1;

  // Reference LFSR: taps 16,14,13,11 of the spec polynomial
  always @(posedge clk50M) begin
    if (!Reset) ref_lfsr <= 16'h0001;
    else        ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  function automatic logic [14:0] V(input logic [1:0] st, input logic [7:0] d, input logic go,
                                    input logic fs, input logic ov, input logic nb, input logic bv);
    return {st, d, go, fs, ov, nb, bv};
  endfunction

  function automatic logic [14:0] cur_vec();
    return {state, disp, go_led, false_start, overflow, new_best, best_valid};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk50M) begin
    if (mon_en) begin
      if (chk_nb) begin
        check("new_best_clear", {31'd0, new_best}, 32'd0);
        chk_nb = 1'b0;
      end
      if (state != prev_state) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_transition: state %b -> %b at cycle %0d", prev_state, state, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.name, "_cycle"}, cyc, e.cyc);
          check({e.name, "_outputs"}, {17'd0, cur_vec()}, {17'd0, e.vec});
        end
        if (state == 2'b11) chk_nb = 1'b1;
      end
      prev_state = state;
    end
  end

  task automatic step();
    @(posedge clk50M);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_round(input string nm, input logic bv, input logic both,
                             input logic push_run, output int r_cyc);
    int rv;
    int e;
    rv = int'(ref_lfsr[1:0]);
    e  = cyc + 1;
    r_cyc = e + (3 + rv) * 4;
    Start = 1'b1;
    Stop  = both;
    q.push_back('{{nm, "_wait"}, e, V(2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, bv)});
    if (push_run) q.push_back('{{nm, "_run"}, r_cyc, V(2'b10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, bv)});
    step();
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  task automatic stop_edge(input string nm, input int edge_c, input logic [14:0] v, input logic both);
    wait_until(edge_c - 1);
    Stop  = 1'b1;
    Start = both;
    q.push_back('{{nm, "_done"}, edge_c, v});
    step();
    Stop  = 1'b0;
    Start = 1'b0;
    step();
    step();
  endtask

  task automatic best_check(input string nm, input logic bv, input logic [7:0] b);
    show_best = 1'b1;
    #1;
    check(nm, {23'd0, best_valid, disp}, {23'd0, bv, b});
    show_best = 1'b0;
  endtask

  int r;

  initial begin
    Reset = 1'b0; Start = 1'b0; Stop = 1'b0; show_best = 1'b0;
    step();
    step();
    check("reset_outputs", {17'd0, cur_vec()}, {17'd0, V(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    best_check("reset_best", 1'b0, 8'h99);
    Reset = 1'b1;
    prev_state = 2'b00;
    mon_en = 1'b1;
    step();
    step();

    start_round("r1", 1'b0, 1'b0, 1'b1, r);
    stop_edge("r1", r + 49, V(2'b11, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
    best_check("r1_best", 1'b1, 8'h12);

    start_round("r2", 1'b1, 1'b0, 1'b1, r);
    stop_edge("r2", r + 61, V(2'b11, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    best_check("r2_best", 1'b1, 8'h12);

    start_round("r3", 1'b1, 1'b0, 1'b1, r);
    stop_edge("r3", r + 49, V(2'b11, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    best_check("r3_equal_best", 1'b1, 8'h12);

    start_round("r4", 1'b1, 1'b0, 1'b1, r);
    stop_edge("r4", r + 29, V(2'b11, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
    best_check("r4_best", 1'b1, 8'h07);

    start_round("fs", 1'b1, 1'b0, 1'b0, r);
    stop_edge("fs", cyc + 4, V(2'b11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    repeat (40) step();
    best_check("fs_best", 1'b1, 8'h07);

    start_round("sat", 1'b1, 1'b0, 1'b1, r);
    wait_until(r + 420);
    check("sat_hold", {17'd0, cur_vec()}, {17'd0, V(2'b10, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1)});
    stop_edge("sat", r + 421, V(2'b11, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
    best_check("sat_best", 1'b1, 8'h07);

    start_round("both_done", 1'b1, 1'b1, 1'b1, r);
    stop_edge("both_run", r + 1, V(2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
    best_check("both_run_best", 1'b1, 8'h00);

    start_round("rst", 1'b1, 1'b0, 1'b1, r);
    wait_until(r + 10);
    Reset = 1'b0;
    q.push_back('{"rst_run_idle", r + 11, V(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    step();
    Reset = 1'b1;
    best_check("rst_run_best", 1'b0, 8'h99);
    step();
    step();

    start_round("both_idle", 1'b0, 1'b1, 1'b1, r);
    wait_until(r + 3);
    repeat (3) step();

    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
